// File: rtl/vldst_pkg.sv
// Shared types and constants for the vector load/store unit.
package vldst_pkg;

    localparam int ELEM_W   = 16;
    localparam int NUM_ELEM = 16;
    localparam int VLEN     = ELEM_W * NUM_ELEM;
    localparam int IDX_W    = 4;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LD_ISSUE,
        LD_LAST,
        LD_WB,
        ST_RD,
        ST_CAP,
        ST_WR,
        DONE
    } state_t;

endpackage

// File: rtl/vldst_addr_gen.sv
// Element counter and address accumulator for one 16-element vector transfer.
// o_last flags element 15; the counter and address hold there until the next load.
module vldst_addr_gen
    import vldst_pkg::*;
#(
    parameter int MADDR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [MADDR_W-1:0] i_base,
    input  logic [MADDR_W-1:0] i_stride,
    output logic [MADDR_W-1:0] o_addr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_last
);

    logic [MADDR_W-1:0] r_addr;
    logic [MADDR_W-1:0] r_stride;
    logic [IDX_W-1:0]   r_idx;
    logic               w_last;

    assign w_last = (r_idx == IDX_W'(NUM_ELEM - 1));

    // Latch base/stride at the start of a transfer, then advance one element per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_stride <= '0;
            r_idx    <= '0;
        end else if (i_load) begin
            r_addr   <= i_base;
            r_stride <= i_stride;
            r_idx    <= '0;
        end else if (i_step && !w_last) begin
            r_addr <= r_addr + r_stride;
            r_idx  <= r_idx + 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_idx  = r_idx;
    assign o_last = w_last;

endmodule

// File: rtl/vector_ldst_unit.sv
// Vector load/store engine: owns the register file write port and read port A.
// Optional build macro VLDST_STRIDE_EN adds a 'stride' input (element address =
// base + i*stride); without it the stride is fixed at 1.
//
// state    | meaning
// IDLE     | waiting for start
// LD_ISSUE | 16 memory reads, capturing the previous element each cycle
// LD_LAST  | capture element 15 (no read)
// LD_WB    | write assembled vector to the register file
// ST_RD    | present source register on VreadA
// ST_CAP   | capture Va into the buffer
// ST_WR    | 16 memory writes from the buffer
// DONE     | one-cycle done pulse
module vector_ldst_unit
    import vldst_pkg::*;
#(
    parameter int MADDR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               op,
    input  logic [2:0]         vreg,
    input  logic [MADDR_W-1:0] base_addr,
`ifdef VLDST_STRIDE_EN
    input  logic [MADDR_W-1:0] stride,
`endif
    output logic               busy,
    output logic               done,
    output logic [MADDR_W-1:0] mem_addr,
    output logic               mem_rd_en,
    input  logic [ELEM_W-1:0]  mem_rd_data,
    output logic               mem_wr_en,
    output logic [ELEM_W-1:0]  mem_wr_data,
    output logic [2:0]         VwrAddr,
    output logic               VwrEn,
    output logic [VLEN-1:0]    Vwrdata,
    output logic [2:0]         VreadA,
    input  logic [VLEN-1:0]    Va
);

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_vreg;
    logic [2:0]         r_vreada;
    logic [VLEN-1:0]    r_buf;
    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic               w_ld_cap;
    logic [IDX_W-1:0]   w_idx;
    logic [MADDR_W-1:0] w_addr;
    logic [MADDR_W-1:0] w_stride;

`ifdef VLDST_STRIDE_EN
    assign w_stride = stride;
`else
    assign w_stride = MADDR_W'(1);
`endif

    assign w_accept = (r_state == IDLE) && start;
    assign w_step   = (r_state == LD_ISSUE) || (r_state == ST_WR);
    // Read data lags the strobe by one cycle, so element 0 arrives in the second issue cycle.
    assign w_ld_cap = ((r_state == LD_ISSUE) && (w_idx != '0)) || (r_state == LD_LAST);

    vldst_addr_gen #(
        .MADDR_W (MADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_base   (base_addr),
        .i_stride (w_stride),
        .o_addr   (w_addr),
        .o_idx    (w_idx),
        .o_last   (w_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        w_next    = r_state;
        busy      = (r_state != IDLE);
        done      = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        VwrEn     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (op == OP_STORE) ? ST_RD : LD_ISSUE;
                end
            end
            LD_ISSUE: begin
                mem_rd_en = 1'b1;
                if (w_last) begin
                    w_next = LD_LAST;
                end
            end
            LD_LAST:  w_next = LD_WB;
            LD_WB: begin
                VwrEn  = 1'b1;
                w_next = DONE;
            end
            ST_RD:    w_next = ST_CAP;
            ST_CAP:   w_next = ST_WR;
            ST_WR: begin
                mem_wr_en = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default:  w_next = IDLE;
        endcase
    end

    // Latch the register index on acceptance; VreadA only moves when a store starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vreg   <= '0;
            r_vreada <= '0;
        end else if (w_accept) begin
            r_vreg <= vreg;
            if (op == OP_STORE) begin
                r_vreada <= vreg;
            end
        end
    end

    // Assembly buffer: loads shift elements in from the top, stores take Va whole.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
        end else if (w_ld_cap) begin
            r_buf <= {mem_rd_data, r_buf[VLEN-1:ELEM_W]};
        end else if (r_state == ST_CAP) begin
            r_buf <= Va;
        end
    end

    assign mem_addr    = w_addr;
    assign mem_wr_data = r_buf[{w_idx, 4'b0000} +: ELEM_W];
    assign VwrAddr     = r_vreg;
    assign Vwrdata     = r_buf;
    assign VreadA      = r_vreada;

endmodule

// File: doc/vector_ldst_unit.md
Name: vector_ldst_unit

Overview:
- Vector load/store engine that owns the write port and read port A of the 8x256-bit vector register file.
- Load: fetches 16 x 16-bit elements from data memory, assembles one 256-bit vector and writes it to the register file in a single write cycle.
- Store: reads a vector from the register file and serializes it to memory as 16 element writes.
- Sits between the instruction controller (start/done handshake) and the data memory.

Parameters:
- ELEM_W, 16, element width in bits.
- NUM_ELEM, 16, elements per vector; ELEM_W*NUM_ELEM = 256.
- MADDR_W, 16, memory address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request pulse; sampled only in IDLE.
- op  input  1  0 = load (mem->vreg), 1 = store (vreg->mem).
- vreg  input  3  target/source vector register index.
- base_addr  input  MADDR_W  address of element 0.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle completion pulse.
- mem_addr  output  MADDR_W  memory element address.
- mem_rd_en  output  1  memory read strobe; data returns 1 cycle later.
- mem_rd_data  input  ELEM_W  read data, valid the cycle after mem_rd_en.
- mem_wr_en  output  1  memory write strobe.
- mem_wr_data  output  ELEM_W  write data.
- VwrAddr  output  3  register file write address.
- VwrEn  output  1  register file write enable.
- Vwrdata  output  256  register file write data.
- VreadA  output  3  register file read address.
- Va  input  256  register file read data; registered, valid 1 cycle after VreadA is presented.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, element counter 0, assembly buffer 0. Reset mid-operation aborts immediately: no further memory or register file strobes, and no done pulse.
- start, op, vreg and base_addr are latched on acceptance. start is ignored while busy.
- States: IDLE, LD_ISSUE, LD_LAST, LD_WB, ST_RD, ST_CAP, ST_WR, DONE.
- IDLE -> LD_ISSUE when start=1 and op=0; IDLE -> ST_RD when start=1 and op=1.
- LD_ISSUE, cycles i = 0..15: mem_rd_en=1, mem_addr = base_addr + i (wraps modulo 2^MADDR_W). From the second cycle, mem_rd_data is captured into buffer bits [16(i-1)+15 : 16(i-1)]. After i=15 -> LD_LAST.
- LD_LAST: mem_rd_en=0; element 15 is captured into bits [255:240]. -> LD_WB.
- LD_WB: VwrEn=1, VwrAddr = latched vreg, Vwrdata = buffer. -> DONE.
- Load latency: 19 cycles from the start-acceptance edge to the done pulse.
- ST_RD: VreadA = vreg. -> ST_CAP.
- ST_CAP: Va is captured into the buffer. -> ST_WR.
- ST_WR, cycles i = 0..15: mem_wr_en=1, mem_addr = base_addr + i, mem_wr_data = buffer[16i+15 : 16i]. After i=15 -> DONE.
- DONE: done=1 for one cycle. -> IDLE. A start arriving in the DONE cycle is ignored; the next start is accepted in IDLE.
- mem_rd_en and mem_wr_en are never high in the same cycle. VwrEn is high for exactly one cycle per load and never during a store.
- VreadA holds its last value when not in ST_RD.
- Vwrdata holds its value after the write; VwrEn qualifies it.

Optional Feature:
- VLDST_STRIDE_EN defined: adds input port stride [MADDR_W-1:0], latched at start; element address = base_addr + i*stride, truncated to MADDR_W. A stride of 0 replicates one element across the vector.
- Macro undefined: no stride port; stride is fixed at 1.

Decomposition:
- Shared package vldst_pkg:
  - state enum;
  - op encoding constants OP_LOAD = 0 and OP_STORE = 1;
  - ELEM_W, NUM_ELEM, VLEN = 256.
- One sub-module, vldst_addr_gen: element counter 0..15, address accumulator (base, plus stride when enabled), and a last flag.

Test Plan:
- Load: memory[0x0100+i] = 0x1000+i, start op=0 vreg=3 base=0x0100 -> 16 reads at 0x0100..0x010F, one VwrEn with VwrAddr=3 and Vwrdata[15:0]=0x1000, Vwrdata[255:240]=0x100F, done 19 cycles after acceptance.
- Store: Va for vreg 5 = {16{0xA5A5}} except element 7 = 0x1234; start op=1 base=0x0200 -> VreadA=5, mem writes 0x0200..0x020F, write to 0x0207 carries 0x1234, no VwrEn.
- Wrap: load with base=0xFFFE -> addresses FFFE, FFFF, 0000..000D.
- start asserted while busy and in the DONE cycle -> ignored; a third start in IDLE is accepted normally.
- rst_n asserted at load element 8 -> all strobes 0 immediately, no VwrEn, no done; a new load after release completes correctly.
- VLDST_STRIDE_EN with stride=4, base=0 -> addresses 0, 4, ..., 60; with stride=0 -> all 16 elements equal memory[0].
